// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the rv32 seven-segment scan controller.
package sevenseg_pkg;

   localparam int unsigned BUS_W = 32;
   localparam int unsigned STRB_W = BUS_W / 8;

   localparam logic [BUS_W-1:0] REG_DATA = 32'h0000_0000;
   localparam logic [BUS_W-1:0] REG_CTRL = 32'h0000_0004;

   localparam int unsigned CTRL_BLANK_LSB  = 0;
   localparam int unsigned CTRL_DP_LSB     = 8;
   localparam int unsigned CTRL_BRIGHT_LSB = 16;
   localparam int unsigned CTRL_EN_BIT     = 31;

   localparam logic [BUS_W-1:0] CTRL_RST  = 32'h800F_0000;
   localparam logic [BUS_W-1:0] CTRL_MASK = 32'h800F_FFFF;

   // Replace each byte lane whose strobe is set; a zero strobe leaves the word unchanged.
   function automatic logic [BUS_W-1:0] merge_bytes(input logic [BUS_W-1:0] old_w,
                                                    input logic [BUS_W-1:0] new_w,
                                                    input logic [STRB_W-1:0] strb);
      logic [BUS_W-1:0] res;
      res = old_w;
      for (int k = 0; k < STRB_W; k++) begin
         if (strb[k]) res[8*k +: 8] = new_w[8*k +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/rv32_sevenseg_scan_if.sv
// PicoRV32 native-bus request/acknowledge bundle.
interface rv32_sevenseg_scan_if;
   import sevenseg_pkg::*;

   logic              rv32_valid;
   logic              rv32_ready;
   logic [BUS_W-1:0]  rv32_addr;
   logic [BUS_W-1:0]  rv32_wdata;
   logic [STRB_W-1:0] rv32_wstrb;
   logic [BUS_W-1:0]  rv32_rdata;

   modport master (output rv32_valid, rv32_addr, rv32_wdata, rv32_wstrb,
                   input  rv32_ready, rv32_rdata);
   modport slave  (input  rv32_valid, rv32_addr, rv32_wdata, rv32_wstrb,
                   output rv32_ready, rv32_rdata);
endinterface

// File: rtl/bin_2_sevenseg.sv
// Hex nibble to active-high segment pattern {g,f,e,d,c,b,a}.
module bin_2_sevenseg (
   input  logic [3:0] bin,
   output logic [6:0] seg_c
);
   always_comb begin
      seg_c = 7'h00;
      case (bin)
         4'h0: seg_c = 7'h3F;
         4'h1: seg_c = 7'h06;
         4'h2: seg_c = 7'h5B;
         4'h3: seg_c = 7'h4F;
         4'h4: seg_c = 7'h66;
         4'h5: seg_c = 7'h6D;
         4'h6: seg_c = 7'h7D;
         4'h7: seg_c = 7'h07;
         4'h8: seg_c = 7'h7F;
         4'h9: seg_c = 7'h6F;
         4'hA: seg_c = 7'h77;
         4'hB: seg_c = 7'h7C;
         4'hC: seg_c = 7'h39;
         4'hD: seg_c = 7'h5E;
         4'hE: seg_c = 7'h79;
         4'hF: seg_c = 7'h71;
         default: seg_c = 7'h00;
      endcase
   end
endmodule

// File: rtl/sevenseg_scan_ctr.sv
// Slot prescaler and digit index; duty is the prescaler's top nibble for PWM dimming.
module sevenseg_scan_ctr #(
   parameter int unsigned DIGITS   = 8,
   parameter int unsigned SCAN_DIV = 1024,
   localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [IDX_W-1:0] idx,
   output logic [3:0]       duty
);
   localparam int unsigned PRE_W = $clog2(SCAN_DIV);

   logic [PRE_W-1:0] presc_q;
   logic             wrap_c;

   assign wrap_c = (presc_q == PRE_W'(SCAN_DIV - 1));
   assign duty   = presc_q[PRE_W-1 -: 4];

   // SCAN_DIV is a power of two, so the prescaler wraps by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         idx     <= '0;
      end else begin
         presc_q <= presc_q + PRE_W'(1);
         if (wrap_c) idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end
   end
endmodule

// File: rtl/rv32_sevenseg_scan.sv
// Memory-mapped multiplexed hex display: DATA/CTRL registers, scan, PWM dimming, registered pins.
module rv32_sevenseg_scan
   import sevenseg_pkg::*;
#(
   parameter int unsigned DIGITS     = 8,
   parameter int unsigned SCAN_DIV   = 1024,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   rv32_sevenseg_scan_if.slave bus,
   output logic [6:0]          seg,
   output logic                dp,
   output logic [DIGITS-1:0]   an
);
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic             ready_q;
   logic [BUS_W-1:0] rdata_q, data_q, ctrl_q;
   logic             sel_ctrl_c, xfer_c;
   logic             unused_addr_bits;

   assign sel_ctrl_c       = bus.rv32_addr[2];
   assign xfer_c           = bus.rv32_valid & ready_q;
   assign unused_addr_bits = ^{bus.rv32_addr[BUS_W-1:3], bus.rv32_addr[1:0]};
   assign bus.rv32_ready   = ready_q;
   assign bus.rv32_rdata   = rdata_q;

   // Single-cycle ack; read data is latched on the request cycle, writes commit on the ack cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
         data_q  <= '0;
         ctrl_q  <= CTRL_RST;
      end else begin
         ready_q <= bus.rv32_valid & ~ready_q;
         if (bus.rv32_valid & ~ready_q) rdata_q <= sel_ctrl_c ? ctrl_q : data_q;
         if (xfer_c && !sel_ctrl_c) data_q <= merge_bytes(data_q, bus.rv32_wdata, bus.rv32_wstrb);
         if (xfer_c && sel_ctrl_c)
            ctrl_q <= merge_bytes(ctrl_q, bus.rv32_wdata, bus.rv32_wstrb) & CTRL_MASK;
      end
   end

   logic [IDX_W-1:0]  idx;
   logic [3:0]        duty;
   logic [2:0]        digit_c;
   logic [3:0]        nibble_c, bright_c;
   logic [7:0]        blank_c, dpm_c;
   logic [6:0]        seg_c;
   logic [DIGITS-1:0] an_c;
   logic              lit_c;

   sevenseg_scan_ctr #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .idx   (idx),
      .duty  (duty)
   );

   assign digit_c  = 3'(idx);
   assign nibble_c = 4'(data_q >> {digit_c, 2'b00});
   assign blank_c  = ctrl_q[CTRL_BLANK_LSB +: 8];
   assign dpm_c    = ctrl_q[CTRL_DP_LSB +: 8];
   assign bright_c = ctrl_q[CTRL_BRIGHT_LSB +: 4];
   assign lit_c    = ctrl_q[CTRL_EN_BIT] & ~blank_c[digit_c] & (duty <= bright_c);
   assign an_c     = DIGITS'(1) << idx;

   bin_2_sevenseg u_dec (
      .bin   (nibble_c),
      .seg_c (seg_c)
   );

   // Output polarity applied at the pin register; dark slots drive everything inactive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= {7{ACTIVE_LOW}};
         dp  <= ACTIVE_LOW;
         an  <= {DIGITS{ACTIVE_LOW}};
      end else if (lit_c) begin
         seg <= seg_c ^ {7{ACTIVE_LOW}};
         dp  <= dpm_c[digit_c] ^ ACTIVE_LOW;
         an  <= an_c ^ {DIGITS{ACTIVE_LOW}};
      end else begin
         seg <= {7{ACTIVE_LOW}};
         dp  <= ACTIVE_LOW;
         an  <= {DIGITS{ACTIVE_LOW}};
      end
   end
endmodule

// File: tb/tb_rv32_sevenseg_scan.sv
// Randomized bench for rv32_sevenseg_scan with a cycle-count based display model.
module tb_rv32_sevenseg_scan;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rv32_sevenseg_scan_if bus ();
   rv32_sevenseg_scan_if bus1 ();

   logic [6:0] seg, seg1;
   logic       dp, dp1;
   logic [7:0] an;
   logic [0:0] an1;

   rv32_sevenseg_scan #(.DIGITS(8), .SCAN_DIV(16), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave), .seg(seg), .dp(dp), .an(an));

   rv32_sevenseg_scan #(.DIGITS(1), .SCAN_DIV(16), .ACTIVE_LOW(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .seg(seg1), .dp(dp1), .an(an1));

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   localparam logic [6:0] ENC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = n[8*k +: 8];
      return r;
   endfunction

   // Model: display state is a pure function of cycles since reset and the register contents.
   logic [31:0] m_data, m_ctrl, m_rd;
   logic        m_rdy, armed, m_lit;
   int unsigned m_cnt;
   int          m_d, m_ph;
   logic [7:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data = 32'h0; m_ctrl = 32'h800F_0000; m_rd = 32'h0;
         m_rdy = 1'b0; armed = 1'b0; m_cnt = 0;
         e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
         m_d   = int'((m_cnt / 16) % 8);
         m_ph  = int'(m_cnt % 16);
         m_lit = m_ctrl[31] && !m_ctrl[m_d] && (m_ph <= int'(m_ctrl[19:16]));
         e_an  = m_lit ? ~(8'(1) << m_d) : 8'hFF;
         e_seg = m_lit ? ~ENC[4'(m_data >> (4 * m_d))] : 7'h7F;
         e_dp  = m_lit ? ~m_ctrl[8 + m_d] : 1'b1;
         if (bus.rv32_valid && m_rdy) begin
            if (bus.rv32_addr[2]) m_ctrl = merge(m_ctrl, bus.rv32_wdata, bus.rv32_wstrb) & 32'h800F_FFFF;
            else                  m_data = merge(m_data, bus.rv32_wdata, bus.rv32_wstrb);
         end else if (bus.rv32_valid) begin
            m_rd = bus.rv32_addr[2] ? m_ctrl : m_data;
         end
         m_rdy = bus.rv32_valid && !m_rdy;
         m_cnt++;
         armed = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (rst_n && armed) begin
         check("an", 32'(an), 32'(e_an));
         check("seg", 32'(seg), 32'(e_seg));
         check("dp", 32'(dp), 32'(e_dp));
         check("ready", 32'(bus.rv32_ready), 32'(m_rdy));
         if (m_rdy) check("rdata", bus.rv32_rdata, m_rd);
         check("an_d1", 32'(an1), 32'h0);
         check("seg_d1", 32'(seg1), 32'h40);
         check("dp_d1", 32'(dp1), 32'h1);
      end
   end

   task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, output logic [31:0] rd, output int lat);
      bus.rv32_addr = addr; bus.rv32_wdata = wdata; bus.rv32_wstrb = strb;
      bus.rv32_valid = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.rv32_ready && lat < 8);
      if (!bus.rv32_ready) check("ready_timeout", 32'(bus.rv32_ready), 32'h1);
      rd = bus.rv32_rdata;
      @(negedge clk);
      bus.rv32_valid = 1'b0; bus.rv32_wstrb = 4'h0;
   endtask

   // Counts over one full 128-cycle scan, starting after a write has settled.
   task automatic scan_window(output int an0_on, output int an3_on, output int dp_on,
                              output int dark_bad, output int dp_bad,
                              output logic [6:0] s0, output logic [6:0] s7);
      an0_on = 0; an3_on = 0; dp_on = 0; dark_bad = 0; dp_bad = 0; s0 = 7'h7F; s7 = 7'h7F;
      repeat (2) @(negedge clk);
      for (int c = 0; c < 128; c++) begin
         if (!an[0]) an0_on++;
         if (!an[3]) an3_on++;
         if (an != 8'hFF) dark_bad++;
         if (!dp) begin dp_on++; if (an != 8'hFD) dp_bad++; end
         if (an == 8'hFE) s0 = seg;
         if (an == 8'h7F) s7 = seg;
         @(negedge clk);
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [6:0]  s0, s7;
      logic [3:0]  pat;
      int lat, a0, a3, dpc, dk, dpb;

      bus.rv32_valid = 1'b0; bus.rv32_addr = '0; bus.rv32_wdata = '0; bus.rv32_wstrb = '0;
      bus1.rv32_valid = 1'b0; bus1.rv32_addr = '0; bus1.rv32_wdata = '0; bus1.rv32_wstrb = '0;
      repeat (3) @(negedge clk);
      check("rst_an", 32'(an), 32'hFF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_ready", 32'(bus.rv32_ready), 32'h0);
      rst_n = 1'b1;

      bus_xfer(32'h4, 32'h0, 4'h0, rd, lat);
      check("ctrl_reset", rd, 32'h800F_0000);
      check("read_latency", 32'(lat), 32'h1);
      bus_xfer(32'h0, 32'h89AB_CDEF, 4'hF, rd, lat);
      check("write_latency", 32'(lat), 32'h1);
      bus_xfer(32'h0, 32'h0, 4'h0, rd, lat);
      check("data_readback", rd, 32'h89AB_CDEF);
      scan_window(a0, a3, dpc, dk, dpb, s0, s7);
      check("digit0_F", 32'(s0), 32'h0E);
      check("digit7_8", 32'(s7), 32'h00);

      bus_xfer(32'h0, 32'hFFFF_FFFF, 4'b0100, rd, lat);
      bus_xfer(32'h0, 32'h0, 4'h0, rd, lat);
      check("byte_strobe", rd, 32'h89FF_CDEF);

      bus_xfer(32'h4, 32'h8000_0201, 4'hF, rd, lat);
      scan_window(a0, a3, dpc, dk, dpb, s0, s7);
      check("blank0_an0", 32'(a0), 32'h0);
      check("dp1_count", 32'(dpc), 32'h1);
      check("dp1_slot", 32'(dpb), 32'h0);

      bus_xfer(32'h4, 32'h8000_0000, 4'hF, rd, lat);
      scan_window(a0, a3, dpc, dk, dpb, s0, s7);
      check("bright0_duty", 32'(a3), 32'h1);
      bus_xfer(32'h4, 32'h8007_0000, 4'hF, rd, lat);
      scan_window(a0, a3, dpc, dk, dpb, s0, s7);
      check("bright7_duty", 32'(a3), 32'h8);
      bus_xfer(32'h4, 32'h000F_0000, 4'hF, rd, lat);
      scan_window(a0, a3, dpc, dk, dpb, s0, s7);
      check("disabled_dark", 32'(dk), 32'h0);
      bus_xfer(32'h4, 32'h800F_0000, 4'hF, rd, lat);

      // Valid held across two reads.
      bus.rv32_addr = 32'h0; bus.rv32_wstrb = 4'h0; bus.rv32_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         pat[i] = bus.rv32_ready;
      end
      bus.rv32_valid = 1'b0;
      check("b2b_ready", 32'(pat), 32'h5);

      for (int i = 0; i < 300; i++) begin
         logic [3:0] strb;
         strb = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         bus_xfer($urandom, $urandom, strb, rd, lat);
         repeat ($urandom_range(0, 12)) @(negedge clk);
      end

      // Reset asserted while a write request is pending.
      bus.rv32_addr = 32'h0; bus.rv32_wdata = 32'hFFFF_FFFF; bus.rv32_wstrb = 4'hF;
      bus.rv32_valid = 1'b1;
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("rst_pending_ready", 32'(bus.rv32_ready), 32'h0);
      bus.rv32_valid = 1'b0; bus.rv32_wstrb = 4'h0;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_no_ready", 32'(bus.rv32_ready), 32'h0);
      bus_xfer(32'h0, 32'h0, 4'h0, rd, lat);
      check("rst_data_zero", rd, 32'h0);
      repeat (20) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end
endmodule
